// File: rtl/spi_ram_arbiter.sv
// Arbitrates one single-port RAM between a decoded SPI command stream and a host port.
// Define SPI_RAM_RR_ARB_EN for round-robin arbitration; default build gives SPI fixed priority.
//
// state      | meaning
// S_IDLE     | pick the next requester, no RAM access
// S_ACC_SPI  | RAM access for the queued SPI command
// S_ACC_HOST | RAM access for the host, host_gnt high
// S_RESP     | ram_rdata valid, latched into tx_data or host_rdata
module spi_ram_arbiter #(
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [9:0]           rx_data,
    input  logic                 rx_valid,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 host_req,
    input  logic                 host_we,
    input  logic [ADDR_SIZE-1:0] host_addr,
    input  logic [7:0]           host_wdata,
    output logic                 host_gnt,
    output logic [7:0]           host_rdata,
    output logic                 host_rvalid,
    output logic                 ram_en,
    output logic                 ram_we,
    output logic [ADDR_SIZE-1:0] ram_addr,
    output logic [7:0]           ram_wdata,
    input  logic [7:0]           ram_rdata,
    output logic                 spi_ovf
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_ACC_SPI  = 2'd1;
    localparam logic [1:0] S_ACC_HOST = 2'd2;
    localparam logic [1:0] S_RESP     = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic [ADDR_SIZE-1:0] pend_addr_q, pend_addr_d;
    logic                 pend_q, pend_d, pend_we_q, pend_we_d;
    logic [7:0]           pend_data_q, pend_data_d;
    logic                 resp_host_q, resp_host_d;
    logic [7:0]           tx_data_q, tx_data_d, host_rdata_q, host_rdata_d;
    logic                 tx_valid_q, tx_valid_d, host_rvalid_q, host_rvalid_d;
    logic                 ovf_q, ovf_d;

    logic [1:0] cmd;
    logic [7:0] payload;
    logic       set, clr, busy, spi_first;

    assign cmd     = rx_data[9:8];
    assign payload = rx_data[7:0];
    assign set     = rx_valid & cmd[0];
    assign clr     = (state_q == S_ACC_SPI);
    assign busy    = pend_q & ~clr;

`ifdef SPI_RAM_RR_ARB_EN
    logic last_host_q, last_host_d;

    // On a tie the requester not served last wins; reset favours SPI.
    assign spi_first = ~host_req | last_host_q;

    always_comb begin
        last_host_d = last_host_q;
        if (state_q == S_ACC_SPI)
            last_host_d = 1'b0;
        else if (state_q == S_ACC_HOST)
            last_host_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            last_host_q <= 1'b1;
        else
            last_host_q <= last_host_d;
    end
`else
    assign spi_first = 1'b1;
`endif

    // Address and data are frozen at accept time; a busy queue drops the new command.
    always_comb begin
        wr_addr_d   = wr_addr_q;
        rd_addr_d   = rd_addr_q;
        pend_d      = pend_q & ~clr;
        pend_we_d   = pend_we_q;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        ovf_d       = 1'b0;
        if (rx_valid && cmd == 2'b00)
            wr_addr_d = ADDR_SIZE'(payload);
        if (rx_valid && cmd == 2'b10)
            rd_addr_d = ADDR_SIZE'(payload);
        if (set) begin
            if (busy) begin
                ovf_d = 1'b1;
            end else begin
                pend_d      = 1'b1;
                pend_we_d   = ~cmd[1];
                pend_addr_d = cmd[1] ? rd_addr_q : wr_addr_q;
                pend_data_d = payload;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        resp_host_d   = resp_host_q;
        tx_data_d     = tx_data_q;
        tx_valid_d    = 1'b0;
        host_rdata_d  = host_rdata_q;
        host_rvalid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pend_q && spi_first)
                    state_d = S_ACC_SPI;
                else if (host_req)
                    state_d = S_ACC_HOST;
            end
            S_ACC_SPI: begin
                resp_host_d = 1'b0;
                state_d     = pend_we_q ? S_IDLE : S_RESP;
            end
            S_ACC_HOST: begin
                resp_host_d = 1'b1;
                state_d     = host_we ? S_IDLE : S_RESP;
            end
            default: begin
                state_d = S_IDLE;
                if (resp_host_q) begin
                    host_rdata_d  = ram_rdata;
                    host_rvalid_d = 1'b1;
                end else begin
                    tx_data_d  = ram_rdata;
                    tx_valid_d = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        host_gnt  = 1'b0;
        if (state_q == S_ACC_SPI) begin
            ram_en    = 1'b1;
            ram_we    = pend_we_q;
            ram_addr  = pend_addr_q;
            ram_wdata = pend_data_q;
        end else if (state_q == S_ACC_HOST) begin
            ram_en    = 1'b1;
            ram_we    = host_we;
            ram_addr  = host_addr;
            ram_wdata = host_wdata;
            host_gnt  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            wr_addr_q     <= '0;
            rd_addr_q     <= '0;
            pend_q        <= 1'b0;
            pend_we_q     <= 1'b0;
            pend_addr_q   <= '0;
            pend_data_q   <= '0;
            resp_host_q   <= 1'b0;
            tx_data_q     <= '0;
            tx_valid_q    <= 1'b0;
            host_rdata_q  <= '0;
            host_rvalid_q <= 1'b0;
            ovf_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_addr_q     <= wr_addr_d;
            rd_addr_q     <= rd_addr_d;
            pend_q        <= pend_d;
            pend_we_q     <= pend_we_d;
            pend_addr_q   <= pend_addr_d;
            pend_data_q   <= pend_data_d;
            resp_host_q   <= resp_host_d;
            tx_data_q     <= tx_data_d;
            tx_valid_q    <= tx_valid_d;
            host_rdata_q  <= host_rdata_d;
            host_rvalid_q <= host_rvalid_d;
            ovf_q         <= ovf_d;
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign host_rdata  = host_rdata_q;
    assign host_rvalid = host_rvalid_q;
    assign spi_ovf     = ovf_q;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed timing checks plus randomized SPI/host traffic against a memory-image model
// for spi_ram_arbiter; the RAM itself is a behavioural array in this bench.
module tb_spi_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       host_req, host_we;
    logic [7:0] host_addr, host_wdata;
    logic       host_gnt;
    logic [7:0] host_rdata;
    logic       host_rvalid;
    logic       ram_en, ram_we;
    logic [7:0] ram_addr, ram_wdata, ram_rdata;
    logic       spi_ovf;

    int tests = 0;
    int fails = 0;

    logic [7:0] mem [256];
    logic [7:0] exp_mem [256];
    logic       mem_init;
    logic [7:0] tx_q [$];
    logic [7:0] host_q [$];
    bit         spi_done, host_done;
    logic [63:0] all_outs;

    always #5 clk = ~clk;

    spi_ram_arbiter #(.ADDR_SIZE(8)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .host_req(host_req), .host_we(host_we),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_gnt(host_gnt),
        .host_rdata(host_rdata), .host_rvalid(host_rvalid), .ram_en(ram_en),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .spi_ovf(spi_ovf)
    );

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
        end else if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    assign all_outs = {26'd0, tx_data, tx_valid, host_gnt, host_rdata, host_rvalid,
                       ram_en, ram_we, ram_addr, ram_wdata, spi_ovf};

    task tick;
        @(posedge clk);
        #1;
    endtask

    task chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task spi(input logic [9:0] w);
        rx_data  = w;
        rx_valid = 1'b1;
        tick;
        rx_valid = 1'b0;
        rx_data  = '0;
    endtask

    // SPI traffic stays in 0x00-0x7F, host traffic in 0x80-0xFF, so each stream
    // sees its own writes in program order regardless of interleaving.
    task automatic spi_driver(input int n);
        logic [7:0] wa, ra, pay;
        int c;
        wa = 8'($urandom_range(0, 127));
        ra = 8'($urandom_range(0, 127));
        spi({2'b00, wa});
        spi({2'b10, ra});
        for (int i = 0; i < n; i++) begin
            c   = int'($urandom_range(0, 3));
            pay = 8'($urandom);
            case (c)
                0: begin wa = pay & 8'h7F; spi({2'b00, wa}); end
                1: begin exp_mem[wa] = pay; spi({2'b01, pay}); repeat (6) tick; end
                2: begin ra = pay & 8'h7F; spi({2'b10, ra}); end
                default: begin tx_q.push_back(exp_mem[ra]); spi({2'b11, pay}); repeat (6) tick; end
            endcase
        end
        spi_done = 1'b1;
    endtask

    task automatic host_driver(input int n);
        int k;
        for (int i = 0; i < n; i++) begin
            host_we    = 1'($urandom_range(0, 1));
            host_addr  = 8'h80 | 8'($urandom_range(0, 127));
            host_wdata = 8'($urandom);
            host_req   = 1'b1;
            if (host_we) exp_mem[host_addr] = host_wdata;
            else         host_q.push_back(exp_mem[host_addr]);
            tick;
            k = 1;
            while (!host_gnt && k < 40) begin tick; k++; end
            chk("rand_host_gnt", host_gnt, 1);
            host_req = 1'b0;
            repeat ($urandom_range(1, 4)) tick;
        end
        host_done = 1'b1;
    endtask

    task automatic monitor;
        int cyc, tail;
        cyc  = 0;
        tail = 0;
        while (tail < 12 && cyc < 20000) begin
            tick;
            cyc++;
            if (spi_done && host_done) tail++;
            if (tx_valid) begin
                chk("rand_tx_expected", tx_q.size() > 0, 1);
                if (tx_q.size() > 0) chk("rand_tx_data", tx_data, tx_q.pop_front());
            end
            if (host_rvalid) begin
                chk("rand_host_expected", host_q.size() > 0, 1);
                if (host_q.size() > 0) chk("rand_host_data", host_rdata, host_q.pop_front());
            end
            if (spi_ovf) chk("rand_no_ovf", spi_ovf, 0);
        end
        chk("rand_within_budget", cyc < 20000, 1);
        chk("rand_tx_drained", tx_q.size(), 0);
        chk("rand_host_drained", host_q.size(), 0);
    endtask

    initial begin
        int k;
        rst_n = 1'b0; rx_data = '0; rx_valid = 1'b0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        spi_done = 1'b0; host_done = 1'b0;
        mem_init = 1'b1;
        for (int i = 0; i < 256; i++) exp_mem[i] = 8'(i) ^ 8'h5A;
        tick; tick;
        mem_init = 1'b0;
        tick;
        chk("reset_outs", all_outs, 0);
        rst_n = 1'b1;
        tick; tick;

        // SPI write then readback of address 5
        spi(10'h005);
        spi(10'h1A5);
        exp_mem[8'h05] = 8'hA5;
        chk("spi_wr_n1_no_acc", ram_en, 0);
        spi(10'h205);
        chk("spi_wr_n2_acc", {ram_en, ram_we, ram_addr, ram_wdata}, {1'b1, 1'b1, 8'h05, 8'hA5});
        spi(10'h300);
        tick;
        chk("spi_rd_n2_acc", {ram_en, ram_we, ram_addr}, {1'b1, 1'b0, 8'h05});
        tick;
        chk("spi_rd_n3_novalid", tx_valid, 0);
        tick;
        chk("spi_rd_n4_valid", {tx_valid, tx_data}, {1'b1, 8'hA5});
        tick;
        chk("spi_tx_hold", {tx_valid, tx_data}, {1'b0, 8'hA5});

        // Host write then read of 0x3C
        host_we = 1'b1; host_addr = 8'h3C; host_wdata = 8'h5A; host_req = 1'b1;
        tick;
        chk("host_wr_gnt", {host_gnt, ram_en, ram_we, ram_addr, ram_wdata},
            {1'b1, 1'b1, 1'b1, 8'h3C, 8'h5A});
        host_req = 1'b0;
        exp_mem[8'h3C] = 8'h5A;
        tick;
        chk("host_gnt_pulse", host_gnt, 0);
        host_we = 1'b0; host_req = 1'b1;
        tick;
        chk("host_rd_gnt", {host_gnt, ram_en, ram_we, ram_addr}, {1'b1, 1'b1, 1'b0, 8'h3C});
        host_req = 1'b0;
        tick;
        chk("host_rd_m2_novalid", host_rvalid, 0);
        tick;
        chk("host_rd_m3_valid", {host_rvalid, host_rdata}, {1'b1, 8'h5A});
        tick;
        chk("host_rvalid_pulse", host_rvalid, 0);

        // Contention: SPI read 0x11 and host read 0x10 pending in the same IDLE cycle
        tick;
        spi(10'h211);
        spi(10'h311);
        host_we = 1'b0; host_addr = 8'h10; host_req = 1'b1;
        tick;
        chk("cont1_spi_first", {ram_en, host_gnt, ram_addr}, {1'b1, 1'b0, 8'h11});
        k = 1;
        while (!host_gnt && k < 20) begin tick; k++; end
        chk("cont1_gnt_latency", k, 4);
        host_req = 1'b0;
        tick; tick;
        chk("cont1_host_data", {host_rvalid, host_rdata}, {1'b1, exp_mem[8'h10]});
        repeat (4) tick;

        // Second pair: another SPI read arrives while the host is still waiting
        spi(10'h311);
        host_addr = 8'h12; host_req = 1'b1;
        tick;
        spi(10'h311);
        k = 2;
        while (!host_gnt && k < 20) begin tick; k++; end
`ifdef SPI_RAM_RR_ARB_EN
        chk("cont2_gnt_latency", k, 4);
`else
        chk("cont2_gnt_latency", k, 7);
`endif
        host_req = 1'b0;
        tick; tick;
        chk("cont2_host_data", {host_rvalid, host_rdata}, {1'b1, exp_mem[8'h12]});
        repeat (8) tick;

        // Overflow: two SPI writes back to back while the host owns the RAM
        spi(10'h040);
        tick;
        host_we = 1'b0; host_addr = 8'h20; host_req = 1'b1;
        tick;
        chk("ovf_host_gnt", host_gnt, 1);
        host_req = 1'b0;
        spi(10'h1AA);
        chk("ovf_first_accepted", spi_ovf, 0);
        spi(10'h1BB);
        chk("ovf_pulse", spi_ovf, 1);
        exp_mem[8'h40] = 8'hAA;
        tick;
        chk("ovf_single_write", {spi_ovf, ram_en, ram_we, ram_addr, ram_wdata},
            {1'b0, 1'b1, 1'b1, 8'h40, 8'hAA});
        repeat (6) tick;

        // Queued write keeps its captured address
        spi(10'h00F);
        spi(10'h177);
        spi(10'h020);
        chk("late_addr_acc", {ram_en, ram_we, ram_addr, ram_wdata}, {1'b1, 1'b1, 8'h0F, 8'h77});
        exp_mem[8'h0F] = 8'h77;
        repeat (3) tick;

        // Reset during ACC_SPI of a read
        spi(10'h230);
        spi(10'h330);
        tick;
        chk("rst_pre_acc", {ram_en, ram_we, ram_addr}, {1'b1, 1'b0, 8'h30});
        rst_n = 1'b0;
        tick;
        chk("rst_mid_outs", all_outs, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("rst_quiet", {tx_valid, ram_en}, 0);
        end
        spi(10'h300);
        tick; tick; tick;
        chk("rst_rd_addr_zero", {tx_valid, tx_data}, {1'b1, exp_mem[8'h00]});
        tick;

        // Randomized concurrent traffic
        fork
            spi_driver(40);
            host_driver(40);
            monitor();
        join

        for (int i = 0; i < 256; i++)
            chk("mem_image", {8'(i), mem[i]}, {8'(i), exp_mem[i]});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_ram_arbiter.md
# spi_ram_arbiter

Shares one single-port RAM between the SPI slave command stream and a local host port. Decodes the SPI slave's 10-bit `rx_data` words into RAM writes and reads, arbitrates them against host requests, drives the RAM control/address/data pins, and returns read data to the SPI slave on `tx_data`/`tx_valid` and to the host on `host_rdata`/`host_rvalid`. Sits between the SPI slave and the RAM, replacing any direct connection between them.

## Interface
- `ADDR_SIZE`, 8: RAM address width; depth is 2^ADDR_SIZE. Data width is fixed at 8.

Ports. Reset `rst_n` is synchronous, active-low; clock is `clk`.
- `clk` in 1: clock, all logic on the rising edge.
- `rst_n` in 1: synchronous active-low reset.
- `rx_data` in 10: SPI word; [9:8] command, [7:0] payload.
- `rx_valid` in 1: one-cycle strobe qualifying `rx_data`.
- `tx_data` out 8: SPI read data; holds its value until the next SPI read completes.
- `tx_valid` out 1: one-cycle strobe qualifying `tx_data`.
- `host_req` in 1: host request, level; held with stable fields until granted.
- `host_we` in 1: 1 = write, 0 = read.
- `host_addr` in ADDR_SIZE: host address.
- `host_wdata` in 8: host write data.
- `host_gnt` out 1: one-cycle pulse; the request is consumed this cycle.
- `host_rdata` out 8: host read data.
- `host_rvalid` out 1: one-cycle strobe qualifying `host_rdata`.
- `ram_en` out 1: RAM access enable.
- `ram_we` out 1: RAM write enable, valid with `ram_en`.
- `ram_addr` out ADDR_SIZE: RAM address.
- `ram_wdata` out 8: RAM write data.
- `ram_rdata` in 8: RAM read data, registered, valid the cycle after a read access.
- `spi_ovf` out 1: one-cycle pulse when an SPI access command is dropped.

## Operation
- SPI decode, on `rx_valid`:
  - `00`: `wr_addr` ← payload.
  - `01`: queue a write of payload to `wr_addr`.
  - `10`: `rd_addr` ← payload.
  - `11`: queue a read from `rd_addr`; payload ignored.
- SPI queue depth is one entry: `pend`, plus captured we/addr/data.
  - Address and data are captured when the command is accepted. Later `00`/`10` commands do not alter a queued access.
- `pend_next = set | (pend & ~clr)`. `clr` is asserted in the ACC_SPI cycle.
  - If `set` occurs while `pend & ~clr`, the new command is dropped and `spi_ovf` pulses.
  - If `set` coincides with `clr`, the new command is accepted without overflow.
- FSM states: IDLE, ACC_SPI, ACC_HOST, RESP.
  - IDLE: selects a requester per the priority rule and goes to the matching ACC state. With nothing pending it stays in IDLE.
  - ACC_x: drives `ram_en`=1, `ram_we`, `ram_addr`, and `ram_wdata`. ACC_HOST also pulses `host_gnt`. Writes go to IDLE; reads go to RESP.
  - RESP: captures `ram_rdata` into `tx_data` or `host_rdata`. The matching valid is high in the following cycle. Then goes to IDLE.
- Priority: fixed, SPI over host, unless `SPI_RAM_RR_ARB_EN` is defined.
- `ram_en`, `ram_we`, `host_gnt`, `tx_valid`, `host_rvalid`, and `spi_ovf` are 0 outside the cycles stated above.
- Dropping `host_req` before `host_gnt` is a protocol violation; the resulting behaviour is undefined.

## Timing
- Reset values: all outputs 0, `tx_data`/`host_rdata` 0, `wr_addr`/`rd_addr` 0, `pend` 0, state IDLE.
- Reset asserted mid-access: the next cycle shows IDLE, `ram_en`=0, and no valid strobe. Queued requests are discarded.
- SPI write, `rx_valid` in cycle N:
  - `pend` is set in N+1 (IDLE decides).
  - `ram_en`/`ram_we` in N+2.
- SPI read, `rx_valid` in cycle N:
  - `ram_en` in N+2; RESP in N+3.
  - `tx_valid` in N+4.
- Host, `host_req` seen in IDLE cycle M:
  - `host_gnt` and RAM access in M+1.
  - Read: `host_rvalid` in M+3.
- Throughput: one write per 2 cycles, one read per 3 cycles. There is always one IDLE cycle between accesses.

## Configuration
- `SPI_RAM_RR_ARB_EN` defined: round-robin arbitration.
  - A `last_host` flag records who was last served; reset value is 1, so SPI wins first.
  - When both requesters are pending in IDLE, the one not served last is granted.
- Not defined: SPI always wins over host. The host may starve.

## Test plan
- Write/readback via SPI: rx `0x005`, `0x1A5`, `0x205`, `0x300` → RAM[5]=0xA5; `tx_data`=0xA5 with `tx_valid` exactly 4 cycles after the `0x300` strobe.
- Host write then host read of addr 0x3C with data 0x5A → `host_gnt` 1 cycle after `host_req`; `host_rvalid` with 0x5A 3 cycles after the read request.
- Contention: `host_req` (read 0x10) and SPI `0x311` become pending in the same IDLE cycle.
  - Fixed mode: SPI is served first and `host_gnt` is delayed 3 cycles.
  - RR mode: a second simultaneous pair serves the host first.
- Overflow: `0x1AA` then `0x1BB` on consecutive cycles while the host holds the RAM → `spi_ovf` pulses once; only 0xAA is written.
- `0x00F`, `0x177`, then `0x020` before the write executes → the write lands at 0x0F, not 0x20.
- Reset asserted during ACC_SPI of a read → no `tx_valid`; all outputs 0 the next cycle; `pend`=0.
